// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: redirect request, instruction-memory port and
// the decoupled instruction stream toward decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds misalign_err.
interface fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  // Fetch unit side
  modport master (
    input  redirect_valid,
    input  redirect_pc,
    input  imem_inst,
    input  out_ready,
    output imem_addr,
    output out_valid,
    output out_inst,
`ifdef FETCH_MISALIGN_CHECK_EN
    output misalign_err,
`endif
    output out_pc
  );

  // Environment side (memory, decode, branch unit)
  modport slave (
    output redirect_valid,
    output redirect_pc,
    output imem_inst,
    output out_ready,
    input  imem_addr,
    input  out_valid,
    input  out_inst,
`ifdef FETCH_MISALIGN_CHECK_EN
    input  misalign_err,
`endif
    input  out_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, combinational instruction-memory
// lookup and a 2-entry {pc, inst} queue toward decode. Redirects flush the
// queue and reload the PC (word-aligned).
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- flags a redirect whose
// target has nonzero low bits with a one-cycle misalign_err pulse.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst_n,
  fetch_if.master bus
);

  logic [31:0] pc_r;
  logic [1:0]  count_r;
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [31:0] mem_pc_r   [2];
  logic [31:0] mem_inst_r [2];

  logic        deq_s;
  logic        enq_s;
  logic        out_valid_s;
  logic [1:0]  count_nxt_s;
  logic [31:0] out_inst_s;
  logic [31:0] out_pc_s;
  logic [31:0] redirect_tgt_s;

  assign out_valid_s    = (count_r != 2'd0);
  assign deq_s          = out_valid_s && bus.out_ready;
  // Redirect wins over any push; a full queue only pushes when it also pops.
  assign enq_s          = !bus.redirect_valid && ((count_r < 2'd2) || deq_s);
  assign redirect_tgt_s = {bus.redirect_pc[31:2], 2'b00};

  assign bus.imem_addr  = {pc_r[31:2], 2'b00};
  assign bus.out_valid  = out_valid_s;
  assign bus.out_inst   = out_inst_s;
  assign bus.out_pc     = out_pc_s;

  // Occupancy after this cycle's push/pop (redirect handled in the register)
  always_comb begin
    count_nxt_s = count_r;
    case ({enq_s, deq_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Queue head presented to decode; empty queue shows a NOP at address 0
  always_comb begin
    out_inst_s = NOP_INST;
    out_pc_s   = 32'h0000_0000;
    if (out_valid_s) begin
      out_inst_s = mem_inst_r[rd_ptr_r];
      out_pc_s   = mem_pc_r[rd_ptr_r];
    end else begin
      out_inst_s = NOP_INST;
      out_pc_s   = 32'h0000_0000;
    end
  end

  // PC, queue pointers/occupancy and queue storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      count_r       <= 2'd0;
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      mem_pc_r[0]   <= 32'h0000_0000;
      mem_pc_r[1]   <= 32'h0000_0000;
      mem_inst_r[0] <= 32'h0000_0000;
      mem_inst_r[1] <= 32'h0000_0000;
    end else if (bus.redirect_valid) begin
      // Flush: any coincident dequeue is consumed along with everything else
      pc_r     <= redirect_tgt_s;
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else begin
      if (enq_s) begin
        mem_pc_r[wr_ptr_r]   <= {pc_r[31:2], 2'b00};
        mem_inst_r[wr_ptr_r] <= bus.imem_inst;
        wr_ptr_r             <= ~wr_ptr_r;
        pc_r                 <= pc_r + 32'd4;  // wraps modulo 2^32
      end
      if (deq_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_nxt_s;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_err_r;
  assign bus.misalign_err = misalign_err_r;

  // One-cycle flag following a redirect to a non-word-aligned target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err_r <= 1'b0;
    end else begin
      misalign_err_r <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    end
  end
`else
  // Low target bits are deliberately dropped when the check is disabled
  logic unused_s;
  assign unused_s = ^bus.redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Instruction memory is modelled
// as inst = ~addr so every fetched word is identifiable by its address.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.imem_inst = ~bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_inst !== 32'h0000_0013) begin n_err++; $display("FAIL reset_inst got %h want 00000013", bus.out_inst); end
    n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus.out_pc); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b want 0", bus.misalign_err); end
`endif
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    apply_reset();
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_first_valid got %b want 0", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = 32'(i * 4);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.out_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, bus.out_pc, exp_pc); end
      n_cmp++; if (bus.out_inst !== ~exp_pc) begin n_err++; $display("FAIL stream_inst[%0d] got %h want %h", i, bus.out_inst, ~exp_pc); end
    end
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL midrst_addr got %h want 0", bus.imem_addr); end
    n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL midrst_pc got %h want 0", bus.out_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.out_pc !== 32'h0 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_first got pc=%h v=%b want pc=0 v=1", bus.out_pc, bus.out_valid); end
    step();
    n_cmp++; if (bus.out_pc !== 32'h4) begin n_err++; $display("FAIL midrst_second got %h want 4", bus.out_pc); end
  endtask

  task automatic test_stall();
    apply_reset();
    rst_n = 1'b1;
    repeat (5) step();
    n_cmp++; if (dut.count_r !== 2'd2) begin n_err++; $display("FAIL stall_count got %0d want 2", dut.count_r); end
    n_cmp++; if (bus.imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_addr got %h want 8", bus.imem_addr); end
    n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL stall_pc got %h want 0", bus.out_pc); end
    n_cmp++; if (bus.out_inst !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL stall_inst got %h want ffffffff", bus.out_inst); end
  endtask

  task automatic test_full_pop();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_pc !== 32'h4) begin n_err++; $display("FAIL pop_pc got %h want 4", bus.out_pc); end
    n_cmp++; if (bus.imem_addr !== 32'hC) begin n_err++; $display("FAIL pop_addr got %h want c", bus.imem_addr); end
    n_cmp++; if (dut.count_r !== 2'd2) begin n_err++; $display("FAIL pop_count got %0d want 2", dut.count_r); end
    step();
    n_cmp++; if (bus.out_pc !== 32'h4 || bus.out_inst !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL pop_hold got pc=%h inst=%h want pc=4 inst=fffffffb", bus.out_pc, bus.out_inst); end
    n_cmp++; if (bus.imem_addr !== 32'hC) begin n_err++; $display("FAIL pop_hold_addr got %h want c", bus.imem_addr); end
  endtask

  task automatic test_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr got %h want 100", bus.imem_addr); end
    n_cmp++; if (bus.out_inst !== 32'h0000_0013) begin n_err++; $display("FAIL redir_nop got %h want 00000013", bus.out_inst); end
    step();
    n_cmp++; if (bus.out_pc !== 32'h100 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL redir_head got pc=%h v=%b want pc=100 v=1", bus.out_pc, bus.out_valid); end
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h200) begin n_err++; $display("FAIL redir_deq got v=%b addr=%h want v=0 addr=200", bus.out_valid, bus.imem_addr); end
    step();
    n_cmp++; if (bus.out_pc !== 32'h200) begin n_err++; $display("FAIL redir_deq_head got %h want 200", bus.out_pc); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_load got %h want fffffffc", bus.imem_addr); end
    step();
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h want 0", bus.imem_addr); end
    n_cmp++; if (bus.out_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_head got %h want fffffffc", bus.out_pc); end
    step();
    n_cmp++; if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_next got pc=%h inst=%h want pc=0 inst=ffffffff", bus.out_pc, bus.out_inst); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_misalign();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL mis_addr got %h want 100", bus.imem_addr); end
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++; if (bus.misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_flag got %b want 1", bus.misalign_err); end
`endif
    step();
    n_cmp++; if (bus.out_pc !== 32'h100) begin n_err++; $display("FAIL mis_head got %h want 100", bus.out_pc); end
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++; if (bus.misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_clear got %b want 0", bus.misalign_err); end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_reset_mid();
    test_stall();
    test_full_pop();
    test_redirect();
    test_wrap();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
